// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu -- registered, handshaked ALU with an iterative multiply/divide unit.
//
// ALU ops finish in one cycle. MDU ops (MUL/MULH/MULHU/DIV/DIVU/REM/REMU)
// iterate one bit per cycle for N cycles, then present the result.
// Results and flags are held until the consumer takes them (out_ready).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operands/op present
//   in_ready   block can accept an op this cycle
//   a, b       N-bit operands
//   control    4-bit ALU op code (ignored when md_en=1)
//   md_en      1 = MDU op selected by md_op
//   md_op      0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 REM, 6 REMU, 7 reserved
//   out_valid  result/flags valid
//   out_ready  consumer takes result this cycle
//   result     registered result
//   overflow   registered overflow flag
//   zero       registered, result == 0
//   equal      registered, a == b of the accepted op
//   busy       MDU iteration in progress
// -----------------------------------------------------------------------------
module alu_mdu #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   control,
  input  logic         md_en,
  input  logic [2:0]   md_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic         equal,
  output logic         busy
);

  localparam int SW = $clog2(N);

  // ALU op codes
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  // MDU op codes
  localparam logic [2:0] MD_MUL   = 3'd0;
  localparam logic [2:0] MD_MULH  = 3'd1;
  localparam logic [2:0] MD_MULHU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_REM   = 3'd5;
  localparam logic [2:0] MD_REMU  = 3'd6;
  localparam logic [2:0] MD_RSVD  = 3'd7;

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Result / flag registers
  logic [N-1:0] result_reg;
  logic         overflow_reg;
  logic         zero_reg;
  logic         equal_reg;

  // MDU working registers. hi/lo form the 2N-bit product accumulator for
  // multiplies and the {remainder, dividend/quotient} pair for divides.
  logic [N-1:0]  hi_reg;
  logic [N-1:0]  lo_reg;
  logic [N-1:0]  d_reg;          // multiplicand or divisor magnitude
  logic [N-1:0]  a_hold_reg;     // original dividend, returned by REM on b=0
  logic [2:0]    op_reg;
  logic          neg_reg;        // negate product (MULH) or quotient (DIV)
  logic          neg_rem_reg;    // negate remainder (REM)
  logic          div_zero_reg;
  logic          ovf_pend_reg;
  logic [SW-1:0] cnt_reg;

  // ---------------------------------------------------------------------------
  // Handshake and FSM
  // ---------------------------------------------------------------------------
  logic accept;
  logic start_mdu;
  logic last_iter;

  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign start_mdu = md_en && (md_op != MD_RSVD);
  assign last_iter = (state_reg == BUSY) && (cnt_reg == SW'(N - 1));

  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == BUSY);
  assign result    = result_reg;
  assign overflow  = overflow_reg;
  assign zero      = zero_reg;
  assign equal     = equal_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = start_mdu ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_next = start_mdu ? BUSY : DONE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  logic [N-1:0]  sum;
  logic [N-1:0]  diff;
  logic [SW-1:0] shamt;
  logic          shift_big;
  logic [N-1:0]  alu_res;
  logic          alu_ovf;

  assign sum       = a + b;
  assign diff      = a - b;
  assign shamt     = b[SW-1:0];
  // Any set bit above the shift-amount field means "shift everything out".
  assign shift_big = |b[N-1:SW];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (control)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = shift_big ? '0 : (a << shamt);
      OP_SRL:  alu_res = shift_big ? '0 : (a >> shamt);
      OP_SRA:  alu_res = shift_big ? {N{a[N-1]}} : $unsigned($signed(a) >>> shamt);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_SLT:  alu_res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(N-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MDU operand preparation (at accept)
  // ---------------------------------------------------------------------------
  logic [N-1:0] mag_a;
  logic [N-1:0] mag_b;
  logic         md_signed;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;

  // Magnitude of the most-negative value wraps back to itself, which is the
  // correct unsigned magnitude 2^(N-1).
  assign mag_a     = a[N-1] ? (~a + 1'b1) : a;
  assign mag_b     = b[N-1] ? (~b + 1'b1) : b;
  assign md_signed = (md_op == MD_MULH) || (md_op == MD_DIV) || (md_op == MD_REM);
  assign op_a      = md_signed ? mag_a : a;
  assign op_b      = md_signed ? mag_b : b;

  // ---------------------------------------------------------------------------
  // MDU iteration step
  // ---------------------------------------------------------------------------
  logic         is_mul;
  logic [N:0]   add_sum;
  logic [N:0]   trial;
  logic [N-1:0] hi_step;
  logic [N-1:0] lo_step;

  assign is_mul  = (op_reg < MD_DIV);
  // Shift-add: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole {carry, hi, lo} right.
  assign add_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, d_reg} : {(N+1){1'b0}});
  // Restoring division: shift the next dividend bit into the partial
  // remainder and try subtracting the divisor.
  assign trial   = {hi_reg, lo_reg[N-1]} - {1'b0, d_reg};

  always_comb begin
    hi_step = hi_reg;
    lo_step = lo_reg;
    if (is_mul) begin
      hi_step = add_sum[N:1];
      lo_step = {add_sum[0], lo_reg[N-1:1]};
    end else if (!trial[N]) begin
      hi_step = trial[N-1:0];
      lo_step = {lo_reg[N-2:0], 1'b1};
    end else begin
      hi_step = {hi_reg[N-2:0], lo_reg[N-1]};
      lo_step = {lo_reg[N-2:0], 1'b0};
    end
  end

  // ---------------------------------------------------------------------------
  // MDU final result, formed from the last step's values
  // ---------------------------------------------------------------------------
  logic [2*N-1:0] prod;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quot;
  logic [N-1:0]   remd;
  logic [N-1:0]   mdu_res;

  assign prod     = {hi_step, lo_step};
  assign prod_fix = neg_reg ? (~prod + 1'b1) : prod;
  assign quot     = neg_reg ? (~lo_step + 1'b1) : lo_step;
  assign remd     = neg_rem_reg ? (~hi_step + 1'b1) : hi_step;

  always_comb begin
    mdu_res = '0;
    case (op_reg)
      MD_MUL:            mdu_res = lo_step;
      MD_MULH:           mdu_res = prod_fix[2*N-1:N];
      MD_MULHU:          mdu_res = hi_step;
      MD_DIV, MD_DIVU:   mdu_res = div_zero_reg ? '1 : quot;
      MD_REM, MD_REMU:   mdu_res = div_zero_reg ? a_hold_reg : remd;
      default:           mdu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
      equal_reg    <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      d_reg        <= '0;
      a_hold_reg   <= '0;
      op_reg       <= '0;
      neg_reg      <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      ovf_pend_reg <= 1'b0;
      cnt_reg      <= '0;
    end else if (accept) begin
      equal_reg <= (a == b);
      if (!md_en) begin
        result_reg   <= alu_res;
        overflow_reg <= alu_ovf;
        zero_reg     <= (alu_res == '0);
      end else if (md_op == MD_RSVD) begin
        result_reg   <= '0;
        overflow_reg <= 1'b0;
        zero_reg     <= 1'b1;
      end else begin
        cnt_reg      <= '0;
        op_reg       <= md_op;
        hi_reg       <= '0;
        lo_reg       <= op_a;
        d_reg        <= op_b;
        a_hold_reg   <= a;
        neg_reg      <= ((md_op == MD_MULH) || (md_op == MD_DIV)) && (a[N-1] ^ b[N-1]);
        neg_rem_reg  <= (md_op == MD_REM) && a[N-1];
        div_zero_reg <= (b == '0);
        ovf_pend_reg <= (md_op == MD_DIV) && (a == MOST_NEG) && (b == '1);
      end
    end else if (state_reg == BUSY) begin
      hi_reg <= hi_step;
      lo_reg <= lo_step;
      if (last_iter) begin
        cnt_reg      <= '0;
        result_reg   <= mdu_res;
        overflow_reg <= ovf_pend_reg;
        zero_reg     <= (mdu_res == '0);
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu -- scoreboard bench for alu_mdu (N=32 main instance, N=16 sweep).
// The driver pushes the expected response of each accepted op into a queue;
// a monitor pops and compares whenever the DUT hands a result over.
// -----------------------------------------------------------------------------
module tb_alu_mdu;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  control = '0;
  logic        md_en = 1'b0;
  logic [2:0]  md_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        overflow;
  logic        zero;
  logic        equal;
  logic        busy;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic [3:0]  control16 = '0;
  logic        md_en16 = 1'b0;
  logic [2:0]  md_op16 = '0;
  logic        out_valid16;
  logic        out_ready16 = 1'b1;
  logic [15:0] result16;
  logic        overflow16;
  logic        zero16;
  logic        equal16;
  logic        busy16;

  always #5 clk = ~clk;

  alu_mdu #(.N(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .control(control), .md_en(md_en), .md_op(md_op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .zero(zero), .equal(equal), .busy(busy)
  );

  alu_mdu #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .control(control16), .md_en(md_en16), .md_op(md_op16),
    .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
    .overflow(overflow16), .zero(zero16), .equal(equal16), .busy(busy16)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        zro;
    logic        eq;
    int          lat;
    int          bsy;
    int          acc;
    logic [3:0]  ctl;
    logic        md;
    logic [2:0]  op;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic rdy_rand = 1'b0;
  logic rdy_val  = 1'b1;

  // monitor state (cleared by the driver on reset)
  int          busy_cnt   = 0;
  logic        first_seen = 1'b0;
  logic        hold_prev  = 1'b0;
  logic [31:0] hold_res   = '0;
  logic        hold_ovf   = 1'b0;
  logic        hold_zro   = 1'b0;
  logic        hold_eq    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic o, input logic z,
                              input logic e, input int l, input int bs);
    exp_t x;
    x.res = r; x.ovf = o; x.zro = z; x.eq = e; x.lat = l; x.bsy = bs;
    x.acc = 0; x.ctl = '0; x.md = 1'b0; x.op = '0;
    return x;
  endfunction

  // Reference model: plain 64-bit arithmetic from the operation definitions.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic [3:0] c, input logic m, input logic [2:0] op);
    exp_t e;
    logic signed [63:0] sx, sy, s;
    logic [63:0] p;
    logic [31:0] r;
    logic o;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    r = '0;
    o = 1'b0;
    e = mk('0, 1'b0, 1'b0, 1'b0, 1, 0);
    if (!m) begin
      case (c)
        4'b0001: r = x & y;
        4'b0010: r = x | y;
        4'b0011: r = x ^ y;
        4'b0101: r = (y >= 32) ? 32'h0 : (x << y[4:0]);
        4'b0110: r = (y >= 32) ? 32'h0 : (x >> y[4:0]);
        4'b0111: begin
          s = sx >>> y[4:0];
          r = (y >= 32) ? {32{x[31]}} : s[31:0];
        end
        4'b1000: begin
          s = sx + sy;
          r = s[31:0];
          o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        4'b1100: begin
          s = sx - sy;
          r = s[31:0];
          o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        4'b1101: r = {31'b0, (sx < sy)};
        4'b1111: r = {31'b0, (x < y)};
        default: r = '0;
      endcase
    end else begin
      if (op != 3'd7) begin
        e.lat = N + 1;
        e.bsy = N;
      end
      case (op)
        3'd0: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; end
        3'd1: begin s = sx * sy; r = s[63:32]; end
        3'd2: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
        3'd3: begin
          if (y == 0) r = '1;
          else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin r = x; o = 1'b1; end
          else begin s = sx / sy; r = s[31:0]; end
        end
        3'd4: r = (y == 0) ? 32'hFFFFFFFF : x / y;
        3'd5: begin
          if (y == 0) r = x;
          else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = '0;
          else begin s = sx % sy; r = s[31:0]; end
        end
        3'd6: r = (y == 0) ? x : x % y;
        default: r = '0;
      endcase
    end
    e.res = r;
    e.ovf = o;
    e.zro = (r == 0);
    e.eq  = (x == y);
    e.ctl = c;
    e.md  = m;
    e.op  = op;
    return e;
  endfunction

  // cycle counter and consumer-side ready generator
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  // Monitor / scoreboard checker
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      busy_cnt   = 0;
      first_seen = 1'b0;
      hold_prev  = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 64'(out_valid), 64'(1'b1));
        chk("hold_result", 64'(result), 64'(hold_res));
        chk("hold_flags", 64'({overflow, zero, equal}), 64'({hold_ovf, hold_zro, hold_eq}));
      end
      if (busy) busy_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          if (!first_seen) begin
            first_seen = 1'b1;
            chk("spurious_out_valid", 64'(out_valid), 64'(1'b0));
          end
        end else begin
          if (!first_seen) begin
            first_seen = 1'b1;
            chk("latency", 64'(cyc - exp_q[0].acc + 1), 64'(exp_q[0].lat));
            chk("busy_cycles", 64'(busy_cnt), 64'(exp_q[0].bsy));
          end
          if (out_ready) begin
            e = exp_q.pop_front();
            chk("result", 64'(result), 64'(e.res));
            chk("overflow", 64'(overflow), 64'(e.ovf));
            chk("zero", 64'(zero), 64'(e.zro));
            chk("equal", 64'(equal), 64'(e.eq));
            $display("txn md=%0d op=%0d ctl=%h result=%h ovf=%0d zero=%0d eq=%0d lat=%0d",
                     e.md, e.op, e.ctl, result, overflow, zero, equal, cyc - e.acc + 1);
            first_seen = 1'b0;
            busy_cnt   = 0;
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_res  = result;
      hold_ovf  = overflow;
      hold_zro  = zero;
      hold_eq   = equal;
    end
  end

  // Present one op, wait (bounded) for its accept, then record the expectation.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] ictl,
                       input logic imd, input logic [2:0] iop, input exp_t e);
    logic got;
    exp_t x;
    @(posedge clk);
    #1;
    a = ia; b = ib; control = ictl; md_en = imd; md_op = iop;
    in_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    if (got) begin
      x = e;
      x.acc = cyc;
      x.ctl = ictl; x.md = imd; x.op = iop;
      exp_q.push_back(x);
    end else begin
      chk("accept_timeout", 64'(got), 64'(1'b1));
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 40));
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run16(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] c,
                       input logic m, input logic [2:0] op, input logic [15:0] er,
                       input int elat, input string nm);
    int lat;
    @(posedge clk);
    #1;
    a16 = ia; b16 = ib; control16 = c; md_en16 = m; md_op16 = op;
    in_valid16 = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, 64'(in_ready16), 64'(1'b1));
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(elat));
    chk({nm, "_result"}, 64'(result16), 64'(er));
    $display("txn16 %s result=%h lat=%0d", nm, result16, lat);
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] C_SRL = 4'b0110;
  localparam logic [3:0] C_SRA = 4'b0111;
  localparam logic [3:0] C_ADD = 4'b1000;
  localparam logic [3:0] C_SUB = 4'b1100;
  localparam logic [3:0] C_SLT = 4'b1101;
  localparam logic [3:0] C_SLL = 4'b0101;

  initial begin
    logic bad;
    logic [31:0] ra, rb;
    logic [3:0]  rc;
    logic        rm;
    logic [2:0]  ro;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({overflow, zero, equal, busy}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
    rst = 1'b0;
    rdy_val = 1'b1;

    // ADD overflow, then reset during a DIVU
    issue(32'h7FFFFFFF, 32'h1, C_ADD, 1'b0, 3'd0, mk(32'h80000000, 1'b1, 1'b0, 1'b0, 1, 0));
    drain();
    issue(32'h12345678, 32'h3, 4'h0, 1'b1, 3'd4, mk(32'h0, 1'b0, 1'b0, 1'b0, N + 1, N));
    repeat (5) @(negedge clk);
    chk("divu_busy", 64'(busy), 64'(1'b1));
    rst = 1'b1;
    #1;
    exp_q.delete();
    busy_cnt = 0; first_seen = 1'b0; hold_prev = 1'b0;
    chk("abort_outputs", 64'({out_valid, overflow, zero, equal, busy}), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_idle", 64'(in_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    bad = 1'b0;
    repeat (N + 5) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("abort_no_valid", 64'(bad), 64'(1'b0));

    // directed ALU and MDU cases
    issue(32'h5, 32'h5, C_SUB, 1'b0, 3'd0, mk(32'h0, 1'b0, 1'b1, 1'b1, 1, 0));
    issue(32'h80000000, 32'h20, C_SRA, 1'b0, 3'd0, mk(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1, 0));
    issue(32'h80000000, 32'h20, C_SRL, 1'b0, 3'd0, mk(32'h0, 1'b0, 1'b1, 1'b0, 1, 0));
    issue(32'hFFFFFFFE, 32'h3, 4'h0, 1'b1, 3'd1, mk(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33, 32));
    issue(32'hFFFFFFFE, 32'h3, 4'h0, 1'b1, 3'd0, mk(32'hFFFFFFFA, 1'b0, 1'b0, 1'b0, 33, 32));
    issue(32'hFFFFFFFE, 32'h3, 4'h0, 1'b1, 3'd2, mk(32'h00000002, 1'b0, 1'b0, 1'b0, 33, 32));
    issue(32'hFFFFFFF9, 32'h2, 4'h0, 1'b1, 3'd3, mk(32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 33, 32));
    issue(32'hFFFFFFF9, 32'h2, 4'h0, 1'b1, 3'd5, mk(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33, 32));
    issue(32'h9, 32'h0, 4'h0, 1'b1, 3'd4, mk(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33, 32));
    issue(32'h9, 32'h0, 4'h0, 1'b1, 3'd6, mk(32'h9, 1'b0, 1'b0, 1'b0, 33, 32));
    issue(32'h80000000, 32'hFFFFFFFF, 4'h0, 1'b1, 3'd3, mk(32'h80000000, 1'b1, 1'b0, 1'b0, 33, 32));
    issue(32'h4, 32'h4, 4'h0, 1'b1, 3'd7, mk(32'h0, 1'b0, 1'b1, 1'b1, 1, 0));
    drain();

    // backpressure: hold the SLT result, then drain it while accepting an ADD
    rdy_val = 1'b0;
    issue(32'hFFFFFFFF, 32'h1, C_SLT, 1'b0, 3'd0, mk(32'h1, 1'b0, 1'b0, 1'b0, 1, 0));
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(1'b0));
      chk("bp_result", 64'(result), 64'd1);
    end
    rdy_val = 1'b1;
    issue(32'h3, 32'h4, C_ADD, 1'b0, 3'd0, mk(32'h7, 1'b0, 1'b0, 1'b0, 1, 0));
    drain();

    // randomized traffic with random backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      ra = rand_val();
      rb = rand_val();
      rm = ($urandom_range(0, 9) < 4);
      rc = 4'($urandom_range(0, 15));
      ro = 3'($urandom_range(0, 7));
      issue(ra, rb, rc, rm, ro, model(ra, rb, rc, rm, ro));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    drain();
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;

    // N=16 instance
    run16(16'hFFFF, 16'hFFFF, 4'h0, 1'b1, 3'd2, 16'hFFFE, 17, "n16_mulhu");
    run16(16'h0001, 16'h0010, C_SLL, 1'b0, 3'd0, 16'h0000, 1, "n16_sll");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, handshaked successor to the single-cycle ALU.
- Registers every result and adds an iterative multiply/divide unit (MDU) that runs one bit per cycle.
- Sits between operand fetch and writeback in the multi-cycle datapath.
- Valid/ready on both sides lets the control FSM stall on long operations.

Parameters:
N, 32, datapath width; any value >= 8. SW = $clog2(N) is the shift-amount width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operands/op present
in_ready  output  1  block can accept an op this cycle
a  input  N  operand A
b  input  N  operand B
control  input  4  alu_control_t ALU op; ignored when md_en=1
md_en  input  1  1 = MDU op selected by md_op
md_op  input  3  0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 REM, 6 REMU, 7 reserved
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result this cycle
result  output  N  registered result
overflow  output  1  registered overflow flag
zero  output  1  registered, result == 0
equal  output  1  registered, a == b of the accepted op
busy  output  1  MDU iteration in progress

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE; out_valid=0, result=0, overflow=0, zero=0, equal=0, busy=0; iteration counter=0. Asserting rst mid-iteration aborts the op, and no result is ever produced for it.
- Acceptance: an op is accepted on a rising edge when in_valid & in_ready.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Back-to-back ops are therefore accepted while a result drains.
- States: IDLE, BUSY, DONE.
  - IDLE -> DONE: accept of an ALU op (md_en=0).
  - IDLE -> BUSY: accept of an MDU op with md_op != 7. md_op=7 goes to DONE with result 0.
  - BUSY -> DONE: when the counter reaches N-1.
  - DONE -> IDLE: on out_ready without a new accept.
  - DONE -> DONE or BUSY: on out_ready with a new accept.
- out_valid = (state==DONE).
- Hold rule: result and flags are stable while out_valid & ~out_ready. Inputs are sampled only on accept.
- Latency (accept edge to out_valid): ALU ops 1 cycle; MDU ops N+1 cycles. busy=1 exactly during BUSY.
- ALU op codes: 0001 AND, 0010 OR, 0011 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 ADD, 1100 SUB, 1101 SLT (signed), 1111 SLTU. All other codes give result 0.
- Shifts: the amount is b[SW-1:0]. If any bit b[N-1:SW] is set, SLL/SRL give 0 and SRA gives N copies of a[N-1].
- overflow:
  - ADD/SUB: signed wrap of the N-bit sum.
  - DIV: 1 for a = most-negative with b = all-ones.
  - All other ops: 0.
- zero and equal are computed from the result and operands of the same accepted op.
- MUL/MULH/MULHU use shift-add over N cycles into a 2N-bit accumulator.
  - MUL returns the low N bits.
  - MULH returns the high N bits of signed x signed. Implemented via operand magnitudes plus sign fix-up of the 2N product.
  - MULHU returns the high N bits of unsigned x unsigned.
- DIV/DIVU/REM/REMU use restoring division over N cycles on magnitudes. Signed quotient sign = a^b sign; remainder sign = sign of a.
- Divide by zero (b=0): DIV/DIVU -> all-ones; REM/REMU -> a; overflow=0. The full N cycles are still taken.
- Signed overflow (a = 100..0, b = all-ones): DIV -> a, REM -> 0, overflow=1.
- Simultaneous events: in_valid while BUSY is not accepted (in_ready=0); the producer must hold its op. out_ready while not out_valid is ignored.

Test Plan:
- N=32, reset mid-flight: ADD a=7FFFFFFF b=1, out_ready=1 -> out_valid one cycle after accept, result=80000000, overflow=1, zero=0. Then rst asserted during a BUSY DIVU -> all outputs 0 immediately, state IDLE, out_valid never rises for the aborted op.
- SUB a=5 b=5 -> result=0, zero=1, equal=1, overflow=0. SRA a=80000000 b=00000020 -> result=FFFFFFFF. SRL with the same operands -> 0.
- MULH a=FFFFFFFE(-2) b=00000003 -> out_valid exactly 33 cycles after accept, busy high 32 cycles, result=FFFFFFFF. MUL with the same operands -> FFFFFFFA. MULHU with the same operands -> 00000002.
- DIV a=FFFFFFF9(-7) b=2 -> FFFFFFFD. REM with the same operands -> FFFFFFFF. DIVU a=9 b=0 -> FFFFFFFF. REMU a=9 b=0 -> 9. DIV a=80000000 b=FFFFFFFF -> 80000000 with overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after an SLT a=FFFFFFFF b=1 -> result stays 1, in_ready=0. Raise out_ready with a new ADD valid -> both handshakes complete on the same edge and ADD appears the next cycle.
- Parameter sweep at N=16: MULHU a=FFFF b=FFFF -> FFFE with latency 17. SLL a=0001 b=0010 -> 0.
